// File: rtl/debounce_pkg.sv
// Shared constants and state encoding for the multi-channel debouncer.
// The optional long-press logic is enabled by defining DEBOUNCE_HOLD_EN.
package debounce_pkg;

  localparam int SYNC_STAGES      = 2;
  localparam int DEF_CLOCKS       = 256;
  localparam int DEF_CLOCKS_CLOG2 = 8;
  localparam int DEF_HOLD_CLOCKS  = 65536;
  localparam int DEF_HOLD_CLOG2   = 16;

  typedef enum logic {
    ST_STABLE = 1'b0,
    ST_COUNT  = 1'b1
  } deb_state_e;

endpackage

// File: rtl/debounce_channel.sv
// One debouncer channel: synchroniser, settle FSM/counter, edge pulses and,
// when DEBOUNCE_HOLD_EN is defined, a saturating long-press detector.
module debounce_channel
  import debounce_pkg::*;
#(
  parameter int CLOCKS       = DEF_CLOCKS,
  parameter int CLOCKS_CLOG2 = DEF_CLOCKS_CLOG2,
  parameter int HOLD_CLOCKS  = DEF_HOLD_CLOCKS,
  parameter int HOLD_CLOG2   = DEF_HOLD_CLOG2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_in,
  output logic debounced,
  output logic rise,
  output logic fall,
  output logic held
);

  localparam logic [CLOCKS_CLOG2-1:0] CNT_LAST = CLOCKS_CLOG2'(CLOCKS - 1);

  if ((CLOCKS < 2) || ((64'd1 << CLOCKS_CLOG2) < 64'(CLOCKS)) ||
      ((64'd1 << HOLD_CLOG2) < 64'(HOLD_CLOCKS))) begin : g_bad_cfg
    $error("debounce_channel: counter widths too narrow for CLOCKS/HOLD_CLOCKS");
  end

  logic [SYNC_STAGES-1:0]  sync_q, sync_d;
  deb_state_e              state_q, state_d;
  logic [CLOCKS_CLOG2-1:0] cnt_q, cnt_d;
  logic                    deb_q, deb_d;
  logic                    rise_q, rise_d;
  logic                    fall_q, fall_d;
  logic                    sync_bit;

  assign sync_d   = {sync_q[SYNC_STAGES-2:0], btn_in};
  assign sync_bit = sync_q[SYNC_STAGES-1];

  // The mismatch is re-tested on the qualifying cycle, so a glitch ending
  // exactly there falls back to STABLE instead of toggling.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    deb_d   = deb_q;
    rise_d  = 1'b0;
    fall_d  = 1'b0;
    case (state_q)
      ST_STABLE: begin
        cnt_d = '0;
        if (sync_bit != deb_q) state_d = ST_COUNT;
      end
      ST_COUNT: begin
        if (sync_bit == deb_q) begin
          state_d = ST_STABLE;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          deb_d   = ~deb_q;
          rise_d  = ~deb_q;
          fall_d  = deb_q;
          state_d = ST_STABLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = ST_STABLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q  <= '0;
      state_q <= ST_STABLE;
      cnt_q   <= '0;
      deb_q   <= 1'b0;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
    end else begin
      sync_q  <= sync_d;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      deb_q   <= deb_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
    end
  end

  assign debounced = deb_q;
  assign rise      = rise_q;
  assign fall      = fall_q;

`ifdef DEBOUNCE_HOLD_EN
  localparam logic [HOLD_CLOG2-1:0] HOLD_LAST = HOLD_CLOG2'(HOLD_CLOCKS - 1);

  logic [HOLD_CLOG2-1:0] hold_cnt_q, hold_cnt_d;
  logic                  held_q, held_d;

  // Both clear on the same edge the debounced level falls.
  always_comb begin
    hold_cnt_d = hold_cnt_q;
    held_d     = held_q;
    if (!deb_d) begin
      hold_cnt_d = '0;
      held_d     = 1'b0;
    end else if (deb_q) begin
      if (hold_cnt_q == HOLD_LAST) held_d = 1'b1;
      else                         hold_cnt_d = hold_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_cnt_q <= '0;
      held_q     <= 1'b0;
    end else begin
      hold_cnt_q <= hold_cnt_d;
      held_q     <= held_d;
    end
  end

  assign held = held_q;
`else
  assign held = 1'b0;
`endif

endmodule

// File: rtl/multi_debouncer.sv
// N independent debouncer channels for raw buttons/switches.
// Define DEBOUNCE_HOLD_EN to enable the per-channel long-press flag on heldOut.
module multi_debouncer
  import debounce_pkg::*;
#(
  parameter int CHANNELS     = 4,
  parameter int CLOCKS       = DEF_CLOCKS,
  parameter int CLOCKS_CLOG2 = DEF_CLOCKS_CLOG2,
  parameter int HOLD_CLOCKS  = DEF_HOLD_CLOCKS,
  parameter int HOLD_CLOG2   = DEF_HOLD_CLOG2
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [CHANNELS-1:0] buttonIn,
  output logic [CHANNELS-1:0] debouncedOut,
  output logic [CHANNELS-1:0] risePulse,
  output logic [CHANNELS-1:0] fallPulse,
  output logic [CHANNELS-1:0] heldOut
);

  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    debounce_channel #(
      .CLOCKS       (CLOCKS),
      .CLOCKS_CLOG2 (CLOCKS_CLOG2),
      .HOLD_CLOCKS  (HOLD_CLOCKS),
      .HOLD_CLOG2   (HOLD_CLOG2)
    ) u_ch (
      .clk       (clk),
      .rst_n     (rst_n),
      .btn_in    (buttonIn[i]),
      .debounced (debouncedOut[i]),
      .rise      (risePulse[i]),
      .fall      (fallPulse[i]),
      .held      (heldOut[i])
    );
  end

endmodule

// File: tb/tb_multi_debouncer.sv
// Directed self-checking bench for multi_debouncer (CHANNELS=4, CLOCKS=4, HOLD_CLOCKS=16).
module tb_multi_debouncer;

`ifdef DEBOUNCE_HOLD_EN
  localparam logic HOLD_ON = 1'b1;
`else
  localparam logic HOLD_ON = 1'b0;
`endif

  logic       clk;
  logic       rst_n;
  logic [3:0] buttonIn;
  logic [3:0] debouncedOut;
  logic [3:0] risePulse;
  logic [3:0] fallPulse;
  logic [3:0] heldOut;

  int tests = 0;
  int fails = 0;

  multi_debouncer #(
    .CHANNELS     (4),
    .CLOCKS       (4),
    .CLOCKS_CLOG2 (2),
    .HOLD_CLOCKS  (16),
    .HOLD_CLOG2   (4)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .buttonIn     (buttonIn),
    .debouncedOut (debouncedOut),
    .risePulse    (risePulse),
    .fallPulse    (fallPulse),
    .heldOut      (heldOut)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic [3:0] d, input logic [3:0] r,
                         input logic [3:0] f);
    chk({tag, ".deb"},  debouncedOut, d);
    chk({tag, ".rise"}, risePulse,    r);
    chk({tag, ".fall"}, fallPulse,    f);
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    rst_n    = 1'b0;
    buttonIn = 4'hF;
    tick(3);
    chk_all("reset", 4'h0, 4'h0, 4'h0);
    chk("reset.held", heldOut, 4'h0);

    // Input high at reset release counts as a press
    rst_n = 1'b1;
    tick(6);
    chk_all("rel_e6", 4'h0, 4'h0, 4'h0);
    tick(1);
    chk_all("rel_e7", 4'hF, 4'hF, 4'h0);
    tick(1);
    chk_all("rel_e8", 4'hF, 4'h0, 4'h0);

    buttonIn = 4'h0;
    tick(6);
    chk_all("allfall_e6", 4'hF, 4'h0, 4'h0);
    tick(1);
    chk_all("allfall_e7", 4'h0, 4'h0, 4'hF);
    tick(1);
    chk_all("allfall_e8", 4'h0, 4'h0, 4'h0);

    // Clean press on ch0 held 20 cycles
    buttonIn = 4'h1;
    tick(6);
    chk_all("ch0_e6", 4'h0, 4'h0, 4'h0);
    tick(1);
    chk_all("ch0_e7", 4'h1, 4'h1, 4'h0);
    tick(1);
    chk_all("ch0_e8", 4'h1, 4'h0, 4'h0);
    tick(12);
    chk_all("ch0_hold", 4'h1, 4'h0, 4'h0);
    buttonIn = 4'h0;
    tick(7);
    chk_all("ch0_rel", 4'h0, 4'h0, 4'h1);
    tick(1);

    // Bounce on ch1
    for (int i = 0; i < 10; i++) begin
      buttonIn = (i % 2 == 0) ? 4'h2 : 4'h0;
      tick(1);
      chk_all("bounce", 4'h0, 4'h0, 4'h0);
    end
    buttonIn = 4'h2;
    tick(6);
    chk_all("bounce_e6", 4'h0, 4'h0, 4'h0);
    tick(1);
    chk_all("bounce_e7", 4'h2, 4'h2, 4'h0);
    for (int i = 0; i < 5; i++) begin
      tick(1);
      chk_all("bounce_after", 4'h2, 4'h0, 4'h0);
    end

    // Simultaneous: ch2 rises while ch3 falls
    buttonIn = 4'hA;
    tick(7);
    chk_all("ch3_up", 4'hA, 4'h8, 4'h0);
    tick(1);
    buttonIn = 4'h6;
    tick(6);
    chk_all("simul_e6", 4'hA, 4'h0, 4'h0);
    tick(1);
    chk_all("simul_e7", 4'h6, 4'h4, 4'h8);
    tick(1);
    chk_all("simul_e8", 4'h6, 4'h0, 4'h0);

    // Reset mid-count on ch0
    buttonIn = 4'h7;
    tick(4);
    chk_all("midcnt", 4'h6, 4'h0, 4'h0);
    rst_n = 1'b0;
    #1;
    chk_all("midcnt_rst", 4'h0, 4'h0, 4'h0);
    chk("midcnt_rst.held", heldOut, 4'h0);
    tick(2);
    chk_all("midcnt_rst2", 4'h0, 4'h0, 4'h0);
    rst_n = 1'b1;
    tick(6);
    chk_all("restart_e6", 4'h0, 4'h0, 4'h0);
    tick(1);
    chk_all("restart_e7", 4'h7, 4'h7, 4'h0);

    // Long press: heldOut 16 cycles after debouncedOut (only with the hold feature)
    tick(15);
    chk("held_e15", heldOut, 4'h0);
    tick(1);
    chk("held_e16", heldOut, HOLD_ON ? 4'h7 : 4'h0);
    tick(14);
    chk("held_sat", heldOut, HOLD_ON ? 4'h7 : 4'h0);
    buttonIn = 4'h0;
    tick(6);
    chk("held_prerel", heldOut, HOLD_ON ? 4'h7 : 4'h0);
    chk_all("held_prerel", 4'h7, 4'h0, 4'h0);
    tick(1);
    chk("held_rel", heldOut, 4'h0);
    chk_all("held_rel", 4'h0, 4'h0, 4'h7);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
